uart_tx_port: RTL and testbench
===============================

Name: uart_tx_port

Overview:
- Memory-mapped serial transmit peripheral, downstream of memory_io_bridge, parallel to the LED and 7-seg registers.
- Consumes CPU writes decoded by the bridge at address 0x6004 (uart_we plus io_data_out).
- Buffers bytes in a small FIFO and shifts them out as 8N1 on the Basys3 USB-UART pin (RsTx).
- Returns a status word that the bridge muxes onto inM when the CPU reads 0x6004.

Parameters:
- CLK_FREQ, 12_500_000, sys_clk frequency in Hz.
- BAUD, 115_200, line rate. DIVISOR = CLK_FREQ / BAUD, integer truncation (108 at defaults). Must be ≥ 2.
- FIFO_DEPTH, 4, transmit FIFO entries. Power of two, ≥ 2.

Ports:
- clk  in  1  system clock (sys_clk domain).
- reset  in  1  asynchronous, active-high reset.
- wr_en  in  1  one-cycle write strobe from the bridge; each high cycle is a separate write.
- wr_data  in  16  CPU write data. Bit 15 = 0: enqueue wr_data[7:0]. Bit 15 = 1: control write.
- status  out  16  bit0 busy, bit1 fifo_full, bit2 fifo_empty, bit3 overflow, bits 15:4 = 0.
- tx  out  1  serial line, idle high.

Behaviour:
Reset (asynchronous, active-high). Takes effect immediately, including mid-frame; the partial frame is abandoned.
- tx = 1
- FIFO empty
- overflow = 0
- state = IDLE
- baud counter = 0
- status = 16'h0004

Write handling:
- Data write (wr_en and wr_data[15] = 0), FIFO not full: push wr_data[7:0]; bits 14:8 are ignored.
- Data write, FIFO full: byte dropped, overflow set.
- A pop in the same cycle frees a slot, so a write to a full FIFO with a simultaneous pop is accepted and does not set overflow.
- Control write (wr_data[15] = 1): clears overflow; nothing is enqueued. If a drop occurs in the same cycle, set wins.
- overflow is sticky until a control write or reset.

Transmit FSM. States IDLE, START, DATA, STOP. Baud counter reloads to DIVISOR-1 on each state entry and on each data-bit advance; a bit period ends when it reaches 0.
- IDLE: tx = 1. If FIFO not empty: pop into an 8-bit shift register and go to START.
- START: tx = 0 for DIVISOR cycles, then go to DATA with bit index = 0.
- DATA: tx = shift[0] for DIVISOR cycles per bit, LSB first. Shift right each bit; after bit index 7 go to STOP.
- STOP: tx = 1 for DIVISOR cycles. At the end:
  - FIFO not empty: pop and go directly to START (no idle gap).
  - FIFO empty: go to IDLE.
- tx is driven from a register (glitch-free).

Latency:
- Data write at edge N into an idle, empty port: FIFO non-empty after N, pop at edge N+1, tx falls after edge N+2.
- One frame = 10 × DIVISOR cycles.

Status:
- Combinational from registers.
- busy = (state != IDLE) OR !fifo_empty.
- fifo_full and fifo_empty reflect the current occupancy.
- Status bits change in the cycle after the causing edge.

Decomposition:
- Shared package hack_io_pkg holds:
  - enum uart_state_t {IDLE, START, DATA, STOP}
  - status bit index constants: ST_BUSY = 0, ST_FULL = 1, ST_EMPTY = 2, ST_OVF = 3
  - constant UART_ADDR = 15'h6004, alongside the existing SEG = 0x6002 and LED = 0x6003 constants, for use by the bridge
  - constant UART_CTRL_BIT = 15
- One sub-module: sync_fifo.
  - Parameterised width and depth.
  - Async reset.
  - push/pop/full/empty, first-word-fall-through data output.
  - Read/write pointers carry one extra bit so full and empty can be distinguished.
- FSM and baud counter live in uart_tx_port.

Test Plan (override CLK_FREQ = 1000, BAUD = 100 → DIVISOR = 10):
1. Reset, then write 16'h0055 → tx falls 2 cycles after the write. Line holds 0 for 10 cycles, then bits 1,0,1,0,1,0,1,0 for 10 cycles each, then 1 for 10 cycles. busy clears one cycle after STOP ends; status = 16'h0004.
2. Four back-to-back writes 0x41 to 0x44 while idle → four contiguous frames totalling 400 cycles with no idle gap. Decoded bytes 0x41 to 0x44 in order.
3. Six writes in six consecutive cycles, depth 4 → the first byte is popped at the second write, so five bytes are accepted. The sixth write hits a full FIFO: status bit3 = 1, bit1 = 1. Only five frames appear on tx.
4. With overflow set, write 16'h8000 → status bit3 = 0 next cycle, FIFO occupancy unchanged, no extra frame.
5. Assert reset mid-DATA (cycle 35 of a frame) → tx = 1 immediately (asynchronous), status = 16'h0004. After release, a new write 0x0F transmits a clean frame.
6. FIFO full and a frame ending in STOP, write 0x7E in the pop cycle → write accepted, overflow stays 0, 0x7E appears as the last frame.

Source files
------------

// File: rtl/hack_io_pkg.sv
// Shared definitions for the Hack memory-mapped I/O blocks: decode addresses,
// UART transmit FSM states and status-word bit positions.
package hack_io_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;

  localparam int unsigned ST_BUSY  = 0;
  localparam int unsigned ST_FULL  = 1;
  localparam int unsigned ST_EMPTY = 2;
  localparam int unsigned ST_OVF   = 3;

  localparam logic [14:0] SEG_ADDR  = 15'h6002;
  localparam logic [14:0] LED_ADDR  = 15'h6003;
  localparam logic [14:0] UART_ADDR = 15'h6004;

  localparam int unsigned UART_CTRL_BIT = 15;

  // Clock cycles per serial bit, truncated.
  function automatic int unsigned baud_divisor(input int unsigned clk_freq,
                                               input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_port_if.sv
// Bridge-side bus for the UART transmit port: write strobe/data in, status and serial line out.
interface uart_tx_port_if;

  logic        wr_en;
  logic [15:0] wr_data;
  logic [15:0] status;
  logic        tx;

  modport master (
    output wr_en,
    output wr_data,
    input  status,
    input  tx
  );

  modport slave (
    input  wr_en,
    input  wr_data,
    output status,
    output tx
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; pointers carry an extra wrap bit so that
// full and empty are distinguishable without an occupancy counter.
module sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [Width-1:0] i_wdata,
  input  logic             i_pop,
  output logic [Width-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [AddrW:0] PtrOne = (AddrW + 1)'(1);

  logic [AddrW:0]   r_wptr;
  logic [AddrW:0]   r_rptr;
  logic [Width-1:0] r_mem [Depth];
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AddrW] != r_rptr[AddrW]) &&
                   (r_wptr[AddrW-1:0] == r_rptr[AddrW-1:0]);

  // A same-cycle pop frees the slot the push lands in.
  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PtrOne;
      if (w_pop)  r_rptr <= r_rptr + PtrOne;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AddrW-1:0]] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rptr[AddrW-1:0]];

endmodule

// File: rtl/uart_tx_port.sv
// Memory-mapped 8N1 serial transmitter: CPU writes queue bytes in a FIFO, an FSM shifts
// them out LSB first, and a status word reports busy/full/empty/overflow.
module uart_tx_port
  import hack_io_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 12_500_000,
  parameter int unsigned BAUD       = 115_200,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic           clk,
  input  logic           reset,
  uart_tx_port_if.slave  bus
);

  localparam int unsigned DIVISOR = baud_divisor(CLK_FREQ, BAUD);
  localparam int unsigned CntW    = $clog2(DIVISOR);
  localparam logic [CntW-1:0] CntReload = CntW'(DIVISOR - 1);
  localparam logic [CntW-1:0] CntOne    = CntW'(1);

  uart_state_t     r_state;
  uart_state_t     w_state_next;
  logic [CntW-1:0] r_baud_cnt;
  logic [CntW-1:0] w_baud_next;
  logic [2:0]      r_bit_idx;
  logic [2:0]      w_bit_next;
  logic [7:0]      r_shift;
  logic [7:0]      w_shift_next;
  logic            r_tx;
  logic            w_tx_next;
  logic            r_overflow;

  logic            w_data_wr;
  logic            w_ctrl_wr;
  logic            w_drop;
  logic            w_pop;
  logic            w_tick;
  logic            w_fifo_full;
  logic            w_fifo_empty;
  logic [7:0]      w_fifo_rdata;

  assign w_data_wr = bus.wr_en && !bus.wr_data[UART_CTRL_BIT];
  assign w_ctrl_wr = bus.wr_en &&  bus.wr_data[UART_CTRL_BIT];
  assign w_drop    = w_data_wr && w_fifo_full && !w_pop;
  assign w_tick    = (r_baud_cnt == '0);

  sync_fifo #(
    .Width (8),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_data_wr),
    .i_wdata (bus.wr_data[7:0]),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  always_comb begin
    w_state_next = r_state;
    w_baud_next  = w_tick ? '0 : r_baud_cnt - CntOne;
    w_bit_next   = r_bit_idx;
    w_shift_next = r_shift;
    w_pop        = 1'b0;

    case (r_state)
      IDLE: begin
        if (!w_fifo_empty) begin
          w_pop        = 1'b1;
          w_shift_next = w_fifo_rdata;
          w_baud_next  = CntReload;
          w_state_next = START;
        end
      end
      START: begin
        if (w_tick) begin
          w_bit_next   = '0;
          w_baud_next  = CntReload;
          w_state_next = DATA;
        end
      end
      DATA: begin
        if (w_tick) begin
          w_baud_next = CntReload;
          if (r_bit_idx == 3'd7) begin
            w_state_next = STOP;
          end else begin
            w_bit_next   = r_bit_idx + 3'd1;
            w_shift_next = {1'b0, r_shift[7:1]};
          end
        end
      end
      STOP: begin
        // Chain straight into the next start bit when more data is queued.
        if (w_tick) begin
          if (!w_fifo_empty) begin
            w_pop        = 1'b1;
            w_shift_next = w_fifo_rdata;
            w_baud_next  = CntReload;
            w_state_next = START;
          end else begin
            w_state_next = IDLE;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_tx_next = 1'b1;
    case (r_state)
      START:   w_tx_next = 1'b0;
      DATA:    w_tx_next = r_shift[0];
      default: w_tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_baud_cnt <= w_baud_next;
      r_bit_idx  <= w_bit_next;
      r_shift    <= w_shift_next;
      r_tx       <= w_tx_next;
      if (w_drop)         r_overflow <= 1'b1;
      else if (w_ctrl_wr) r_overflow <= 1'b0;
    end
  end

  always_comb begin
    bus.status           = '0;
    bus.status[ST_BUSY]  = (r_state != IDLE) || !w_fifo_empty;
    bus.status[ST_FULL]  = w_fifo_full;
    bus.status[ST_EMPTY] = w_fifo_empty;
    bus.status[ST_OVF]   = r_overflow;
  end

  assign bus.tx = r_tx;

endmodule

// File: tb/tb_uart_tx_port.sv
// Bench for uart_tx_port: a frame-level reference model (byte queue plus time left in the
// current frame) predicts tx and status every cycle; a line decoder recovers sent bytes.
module tb_uart_tx_port;

  localparam int ClkFreq = 1000;
  localparam int Baud    = 100;
  localparam int Div     = ClkFreq / Baud;
  localparam int Depth   = 4;
  localparam int Frame   = 10 * Div;

  logic clk = 1'b0;
  logic reset;

  uart_tx_port_if bus ();

  uart_tx_port #(
    .CLK_FREQ   (ClkFreq),
    .BAUD       (Baud),
    .FIFO_DEPTH (Depth)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [7:0]  m_q[$];
  int          m_fl;
  logic [7:0]  m_cur;
  logic        m_ovf;
  logic        m_tx;
  logic [15:0] m_status;
  logic [7:0]  exp_bytes[$];
  logic [7:0]  rx_bytes[$];

  // Line level for a frame with fl cycles remaining; fl == 0 means idle.
  function automatic logic line_bit(input int fl, input logic [7:0] b);
    int pos;
    if (fl == 0) return 1'b1;
    pos = (Frame - fl) / Div;
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return b[pos-1];
  endfunction

  task automatic model_clear();
    m_q.delete();
    exp_bytes.delete();
    rx_bytes.delete();
    m_fl     = 0;
    m_cur    = '0;
    m_ovf    = 1'b0;
    m_tx     = 1'b1;
    m_status = 16'h0004;
  endtask

  // Drive one cycle of bus input, advance the model across the edge, return #1 after it.
  task automatic step(input logic we, input logic [15:0] d);
    logic pop, acc, is_data;
    bus.wr_en   = we;
    bus.wr_data = d;
    @(posedge clk);
    m_tx    = line_bit(m_fl, m_cur);
    is_data = we && !d[15];
    pop     = (m_q.size() > 0) && (m_fl <= 1);
    acc     = is_data && ((m_q.size() < Depth) || pop);
    if (m_fl > 0) m_fl--;
    if (pop) begin
      m_cur = m_q.pop_front();
      m_fl  = Frame;
      exp_bytes.push_back(m_cur);
    end
    if (acc) m_q.push_back(d[7:0]);
    if (is_data && !acc) m_ovf = 1'b1;
    else if (we && d[15]) m_ovf = 1'b0;
    m_status = {12'h000, m_ovf, m_q.size() == 0, m_q.size() == Depth,
                (m_fl > 0) || (m_q.size() > 0)};
    #1;
    bus.wr_en = 1'b0;
  endtask

  // Line decoder: samples mid-bit on falling clock edges.
  int         mon_cnt = 0;
  logic       mon_in  = 1'b0;
  logic [7:0] mon_sh  = '0;

  always @(negedge clk) begin
    if (reset) begin
      mon_in <= 1'b0;
    end else if (!mon_in) begin
      if (bus.tx == 1'b0) begin
        mon_in  <= 1'b1;
        mon_cnt <= 1;
      end
    end else begin
      mon_cnt <= mon_cnt + 1;
      if ((mon_cnt % Div) == Div / 2 && mon_cnt >= Div && mon_cnt < 9 * Div)
        mon_sh[mon_cnt / Div - 1] <= bus.tx;
      if (mon_cnt == 9 * Div + Div / 2) rx_bytes.push_back(mon_sh);
      if (mon_cnt == Frame - 1) mon_in <= 1'b0;
    end
  end

  task automatic test_reset();
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    reset       = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.tx !== 1'b1) begin
      failures++;
      $display("FAIL reset_tx: got %b expected 1", bus.tx);
    end
    checks++;
    if (bus.status !== 16'h0004) begin
      failures++;
      $display("FAIL reset_status: got %h expected 0004", bus.status);
    end
    reset = 1'b0;
    model_clear();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 16'h0000);
      checks++;
      if (bus.status !== m_status || bus.tx !== m_tx) begin
        failures++;
        $display("FAIL post_reset cyc %0d: got %h/%b expected %h/%b",
                 i, bus.status, bus.tx, m_status, m_tx);
      end
    end
  endtask

  task automatic test_single_frame();
    step(1'b1, 16'h0055);
    for (int i = 0; i < Frame + 6; i++) begin
      step(1'b0, 16'h0000);
      checks++;
      if (bus.tx !== m_tx) begin
        failures++;
        $display("FAIL single_tx cyc %0d: got %b expected %b", i, bus.tx, m_tx);
      end
      checks++;
      if (bus.status !== m_status) begin
        failures++;
        $display("FAIL single_status cyc %0d: got %h expected %h", i, bus.status, m_status);
      end
    end
    checks++;
    if (bus.status !== 16'h0004) begin
      failures++;
      $display("FAIL single_final_status: got %h expected 0004", bus.status);
    end
    checks++;
    if (rx_bytes.size() != 1 || rx_bytes[0] !== 8'h55) begin
      failures++;
      $display("FAIL single_byte: got %0d bytes first %h expected 1 byte 55",
               rx_bytes.size(), (rx_bytes.size() > 0) ? rx_bytes[0] : 8'hxx);
    end
    exp_bytes.delete();
    rx_bytes.delete();
  endtask

  task automatic test_back_to_back();
    for (int b = 0; b < 4; b++) begin
      step(1'b1, {1'b0, 7'($urandom), 8'(8'h41 + b)});
      checks++;
      if (bus.status !== m_status) begin
        failures++;
        $display("FAIL b2b_fill_status %0d: got %h expected %h", b, bus.status, m_status);
      end
    end
    for (int i = 0; i < 4 * Frame + 4; i++) begin
      step(1'b0, 16'h0000);
      checks++;
      if (bus.tx !== m_tx || bus.status !== m_status) begin
        failures++;
        $display("FAIL b2b_line cyc %0d: got %b/%h expected %b/%h",
                 i, bus.tx, bus.status, m_tx, m_status);
      end
    end
    checks++;
    if (rx_bytes.size() != 4) begin
      failures++;
      $display("FAIL b2b_count: got %0d expected 4", rx_bytes.size());
    end else begin
      for (int b = 0; b < 4; b++) begin
        checks++;
        if (rx_bytes[b] !== 8'(8'h41 + b)) begin
          failures++;
          $display("FAIL b2b_byte %0d: got %h expected %h", b, rx_bytes[b], 8'(8'h41 + b));
        end
      end
    end
    exp_bytes.delete();
    rx_bytes.delete();
  endtask

  task automatic test_overflow();
    for (int b = 0; b < 6; b++) begin
      step(1'b1, {1'b0, 7'($urandom), 8'($urandom)});
      checks++;
      if (bus.status !== m_status || bus.tx !== m_tx) begin
        failures++;
        $display("FAIL ovf_write %0d: got %h/%b expected %h/%b",
                 b, bus.status, bus.tx, m_status, m_tx);
      end
    end
    checks++;
    if (bus.status[3] !== 1'b1 || bus.status[1] !== 1'b1) begin
      failures++;
      $display("FAIL ovf_flags: got ovf=%b full=%b expected 1/1", bus.status[3], bus.status[1]);
    end
  endtask

  task automatic test_ctrl_clear();
    step(1'b1, 16'h8000 | 16'($urandom_range(0, 16'h7fff)));
    checks++;
    if (bus.status !== m_status || bus.status[3] !== 1'b0 || bus.status[1] !== 1'b1) begin
      failures++;
      $display("FAIL ctrl_clear: got %h expected %h (ovf 0, full 1)", bus.status, m_status);
    end
    for (int i = 0; i < 6 * Frame && !(m_fl == 0 && m_q.size() == 0); i++) begin
      step(1'b0, 16'h0000);
      checks++;
      if (bus.tx !== m_tx || bus.status !== m_status) begin
        failures++;
        $display("FAIL ctrl_drain cyc %0d: got %b/%h expected %b/%h",
                 i, bus.tx, bus.status, m_tx, m_status);
      end
    end
    repeat (2) step(1'b0, 16'h0000);
    checks++;
    if (bus.status !== 16'h0004) begin
      failures++;
      $display("FAIL ctrl_drain_idle: got %h expected 0004", bus.status);
    end
    checks++;
    if (rx_bytes.size() != 5 || rx_bytes != exp_bytes) begin
      failures++;
      $display("FAIL ovf_frames: got %0d frames expected 5 matching model", rx_bytes.size());
    end
    exp_bytes.delete();
    rx_bytes.delete();
  endtask

  task automatic test_reset_mid_frame();
    step(1'b1, {8'h00, 8'($urandom) | 8'h01});
    for (int i = 0; i < 36; i++) step(1'b0, 16'h0000);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.tx !== 1'b1) begin
      failures++;
      $display("FAIL midreset_tx: got %b expected 1", bus.tx);
    end
    checks++;
    if (bus.status !== 16'h0004) begin
      failures++;
      $display("FAIL midreset_status: got %h expected 0004", bus.status);
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
    step(1'b1, 16'h000F);
    for (int i = 0; i < Frame + 4; i++) begin
      step(1'b0, 16'h0000);
      checks++;
      if (bus.tx !== m_tx || bus.status !== m_status) begin
        failures++;
        $display("FAIL midreset_frame cyc %0d: got %b/%h expected %b/%h",
                 i, bus.tx, bus.status, m_tx, m_status);
      end
    end
    checks++;
    if (rx_bytes.size() != 1 || rx_bytes[0] !== 8'h0F) begin
      failures++;
      $display("FAIL midreset_byte: got %0d bytes expected one 0F", rx_bytes.size());
    end
    exp_bytes.delete();
    rx_bytes.delete();
  endtask

  task automatic test_write_in_pop_cycle();
    for (int b = 0; b < 5; b++) step(1'b1, {8'h00, 8'($urandom)});
    checks++;
    if (bus.status[1] !== 1'b1) begin
      failures++;
      $display("FAIL popcyc_full: got %b expected 1", bus.status[1]);
    end
    for (int i = 0; i < 2 * Frame && m_fl != 1; i++) begin
      step(1'b0, 16'h0000);
      checks++;
      if (bus.tx !== m_tx || bus.status !== m_status) begin
        failures++;
        $display("FAIL popcyc_wait cyc %0d: got %b/%h expected %b/%h",
                 i, bus.tx, bus.status, m_tx, m_status);
      end
    end
    step(1'b1, 16'h007E);
    checks++;
    if (bus.status[3] !== 1'b0 || bus.status[1] !== 1'b1) begin
      failures++;
      $display("FAIL popcyc_accept: got ovf=%b full=%b expected 0/1", bus.status[3], bus.status[1]);
    end
    for (int i = 0; i < 6 * Frame && !(m_fl == 0 && m_q.size() == 0); i++) begin
      step(1'b0, 16'h0000);
      checks++;
      if (bus.tx !== m_tx || bus.status !== m_status) begin
        failures++;
        $display("FAIL popcyc_drain cyc %0d: got %b/%h expected %b/%h",
                 i, bus.tx, bus.status, m_tx, m_status);
      end
    end
    repeat (2) step(1'b0, 16'h0000);
    checks++;
    if (rx_bytes.size() != 6 || rx_bytes[rx_bytes.size()-1] !== 8'h7E) begin
      failures++;
      $display("FAIL popcyc_last: got %0d frames expected 6 ending in 7E", rx_bytes.size());
    end
    exp_bytes.delete();
    rx_bytes.delete();
  endtask

  task automatic test_random();
    for (int i = 0; i < 2500; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 5)      step(1'b1, {1'b0, 15'($urandom)});
      else if (r < 7) step(1'b1, {1'b1, 15'($urandom)});
      else            step(1'b0, 16'($urandom));
      checks++;
      if (bus.tx !== m_tx || bus.status !== m_status) begin
        failures++;
        $display("FAIL random cyc %0d: got %b/%h expected %b/%h",
                 i, bus.tx, bus.status, m_tx, m_status);
      end
    end
    for (int i = 0; i < 6 * Frame && !(m_fl == 0 && m_q.size() == 0); i++) begin
      step(1'b0, 16'h0000);
      checks++;
      if (bus.tx !== m_tx || bus.status !== m_status) begin
        failures++;
        $display("FAIL random_drain cyc %0d: got %b/%h expected %b/%h",
                 i, bus.tx, bus.status, m_tx, m_status);
      end
    end
    repeat (2) step(1'b0, 16'h0000);
    checks++;
    if (rx_bytes != exp_bytes) begin
      failures++;
      $display("FAIL random_bytes: got %0d frames expected %0d (or content differs)",
               rx_bytes.size(), exp_bytes.size());
    end
    checks++;
    if (bus.status[2:0] !== 3'b100) begin
      failures++;
      $display("FAIL random_idle: got %b expected 100", bus.status[2:0]);
    end
  endtask

  initial begin
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    reset       = 1'b1;
    model_clear();
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_overflow();
    test_ctrl_clear();
    test_reset_mid_frame();
    test_write_in_pop_cycle();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
